camera_config_ctrl: RTL and testbench
=====================================

Name: camera_config_ctrl

Overview:
Sequences the OV7670 register-initialisation table after power-up or on request.
- Walks the 8-bit ROM index and decodes each 16-bit entry {sub_addr[15:8], value[7:0]}.
- Issues one write per entry to the SCCB write master over a valid/ready + done handshake.
- Sentinel entries: 16'hFFF0 inserts a settle delay; 16'hFFFF terminates the table.
- Sits between the init ROM and the SCCB master; its `done` output gates the camera capture path.

Parameters:
- DELAY_CYCLES, 250000: clk cycles per FFF0 delay entry (10 ms at 25 MHz); must be ≥1.
- MAX_ENTRIES, 255: index limit; reaching it without FFFF ends the sequence with error.
- TIMEOUT_CYCLES, 1000000: watchdog limit per SCCB write (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level/pulse; sampled in IDLE and DONE to begin a pass.
- rom_select  out  8  ROM index.
- rom_out  in  16  ROM data; registered, valid exactly 1 cycle after rom_select changes.
- sccb_valid  out  1  write request; held until accepted.
- sccb_addr  out  8  register sub-address; stable while sccb_valid is high.
- sccb_data  out  8  register value; stable while sccb_valid is high.
- sccb_ready  in  1  master can accept a request.
- sccb_done  in  1  1-cycle pulse when the accepted write completes on the bus.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  high in DONE until the next start.
- error  out  1  sticky per pass; set on overrun (or timeout); cleared on start.

Behaviour:
- Reset (synchronous, rst high at posedge): state=IDLE; rom_select=0; sccb_valid=0; sccb_addr=0; sccb_data=0; busy=0; done=0; error=0; delay counter=0. rst mid-pass aborts immediately, including with a request outstanding; a later sccb_done is ignored.
- States: IDLE, FETCH, DECODE, DELAY, SEND, WAIT_DONE, DONE.
- IDLE: on start, rom_select←0, busy←1, error←0 → FETCH.
- FETCH: one cycle for ROM latency → DECODE.
- DECODE, examines rom_out:
  - 16'hFFFF → DONE.
  - 16'hFFF0 → load counter with DELAY_CYCLES-1 → DELAY.
  - Otherwise → latch sccb_addr/sccb_data, sccb_valid←1 → SEND.
  - Only the exact values FFFF and FFF0 are special; other FFxx entries are written normally.
- DELAY: decrement each cycle; at 0, advance → FETCH.
  - An FFF0 entry costs DELAY_CYCLES+2 cycles (FETCH + DECODE + delay).
- SEND: on cycle with sccb_valid && sccb_ready, sccb_valid←0 → WAIT_DONE. addr/data must not change while valid is high.
- WAIT_DONE: on sccb_done, advance → FETCH. A sccb_done arriving in any other state is ignored.
- Advance: if rom_select==MAX_ENTRIES, error←1 → DONE; else rom_select←rom_select+1. The index never wraps.
- DONE: busy←0, done←1. On start: done←0, error←0, rom_select←0, busy←1 → FETCH (re-run).
- busy and done are never high simultaneously.
- Minimum per-write overhead: FETCH + DECODE + SEND(≥1) + WAIT_DONE(≥1) = 4 cycles.
- start while busy is ignored.

Optional Feature:
- CAM_CFG_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in SEND + WAIT_DONE for each entry.
  - Reaching TIMEOUT_CYCLES: sccb_valid←0, error←1 → DONE.
  - The counter clears on each advance.
- Not defined: no watchdog logic; the controller waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package cam_cfg_pkg:
  - State enum.
  - Constants ROM_END=16'hFFFF and ROM_DELAY=16'hFFF0.
  - ROM_IDX_W=8.
- Sub-module cam_cfg_delay_cnt: loadable down-counter with zero flag; reused for the delay and the watchdog.
- FSM and handshake logic stay in the top level.

Test Plan:
- Reset/idle: rst 3 cycles, then idle 10 cycles → all outputs 0, rom_select=0, no sccb_valid.
- Normal table: ROM model {1280, FFF0, 1214, FFFF}, DELAY_CYCLES=5, master ready=1 with done 3 cycles after accept → writes (12,80) then (12,14) in order; gap between the two accepts ≥7 cycles; done=1, busy=0, error=0.
- Backpressure: hold sccb_ready=0 for 20 cycles while valid → sccb_valid stays 1 with addr/data stable for all 20 cycles; exactly one accept.
- Overrun: ROM with no FFFF, MAX_ENTRIES=4 → exactly 5 writes, then error=1, done=1.
- Reset mid-pass: assert rst in WAIT_DONE, then pulse sccb_done → state IDLE; no further writes; outputs at reset values.
- Timeout (CAM_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=50): sccb_ready held 0 → after 50 cycles sccb_valid=0, error=1, done=1; a subsequent start clears error and restarts at index 0.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera
// register-init sequencer.
package cam_cfg_pkg;

  localparam int ROM_IDX_W = 8;

  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DELAY,
    S_SEND,
    S_WAIT_DONE,
    S_DONE
  } state_t;

endpackage

// File: rtl/camera_config_ctrl_if.sv
// SCCB write-request bundle: valid/ready
// request plus a completion pulse.
interface camera_config_ctrl_if;

  logic       sccb_valid;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_ready;
  logic       sccb_done;

  modport master (
    output sccb_valid,
    output sccb_addr,
    output sccb_data,
    input  sccb_ready,
    input  sccb_done
  );

  modport slave (
    input  sccb_valid,
    input  sccb_addr,
    input  sccb_data,
    output sccb_ready,
    output sccb_done
  );

endinterface

// File: rtl/cam_cfg_delay_cnt.sv
// Loadable down-counter that stops at zero;
// used for settle delays and the watchdog.
module cam_cfg_delay_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // load has priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/camera_config_ctrl.sv
// OV7670 init-table sequencer: ROM walk, SCCB writes.
// Optional watchdog: define CAM_CFG_TIMEOUT_EN.
module camera_config_ctrl
  import cam_cfg_pkg::*;
#(
  parameter int DELAY_CYCLES   = 250000,
  parameter int MAX_ENTRIES    = 255,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  output logic [ROM_IDX_W-1:0] o_rom_select,
  input  logic [15:0]          i_rom_out,
  camera_config_ctrl_if.master sccb,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  // one counter width serves both delay and watchdog
  localparam int CNT_MAX = (DELAY_CYCLES > TIMEOUT_CYCLES)
                         ? DELAY_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DLY_LOAD =
    CNT_W'(DELAY_CYCLES - 1);
  localparam logic [ROM_IDX_W-1:0] MAX_IDX =
    ROM_IDX_W'(MAX_ENTRIES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ROM_IDX_W-1:0] r_sel;
  logic [ROM_IDX_W-1:0] w_sel_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic [7:0]           r_addr;
  logic [7:0]           w_addr_nxt;
  logic [7:0]           r_data;
  logic [7:0]           w_data_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_err;
  logic                 w_err_nxt;

  logic w_dly_load;
  logic w_dly_dec;
  logic w_dly_zero;
  logic w_adv;
  logic w_at_max;
  logic w_in_xfer;
  logic w_timeout;

  assign w_at_max  = (r_sel == MAX_IDX);
  assign w_in_xfer = (r_state == S_SEND) ||
                     (r_state == S_WAIT_DONE);

  cam_cfg_delay_cnt #(.W(CNT_W)) u_dly (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_dly_load),
    .i_load_val (DLY_LOAD),
    .i_dec      (w_dly_dec),
    .o_zero     (w_dly_zero)
  );

`ifdef CAM_CFG_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LOAD =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic w_wd_zero;

  // reloaded whenever no write is in flight
  cam_cfg_delay_cnt #(.W(CNT_W)) u_wd (
    .clk        (clk),
    .rst        (rst),
    .i_load     (!w_in_xfer),
    .i_load_val (WD_LOAD),
    .i_dec      (w_in_xfer),
    .o_zero     (w_wd_zero)
  );

  assign w_timeout = w_in_xfer && w_wd_zero;
`else
  assign w_timeout = 1'b0;
`endif

  // next-state and next-register decode
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;
    w_dly_load  = 1'b0;
    w_dly_dec   = 1'b0;
    w_adv       = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_sel_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (i_rom_out == ROM_END): begin
            w_state_nxt = S_DONE;
          end
          (i_rom_out == ROM_DELAY): begin
            w_dly_load  = 1'b1;
            w_state_nxt = S_DELAY;
          end
          default: begin
            w_addr_nxt  = i_rom_out[15:8];
            w_data_nxt  = i_rom_out[7:0];
            w_valid_nxt = 1'b1;
            w_state_nxt = S_SEND;
          end
        endcase
      end
      S_DELAY: begin
        if (w_dly_zero) w_adv = 1'b1;
        else            w_dly_dec = 1'b1;
      end
      S_SEND: begin
        if (r_valid && sccb.sccb_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (sccb.sccb_done) begin
          w_adv = 1'b1;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // index never wraps: the last slot ends the pass
    if (w_adv) begin
      if (w_at_max) begin
        w_err_nxt   = 1'b1;
        w_state_nxt = S_DONE;
      end else begin
        w_sel_nxt   = r_sel + 1'b1;
        w_state_nxt = S_FETCH;
      end
    end

    w_busy_nxt = (w_state_nxt != S_IDLE) &&
                 (w_state_nxt != S_DONE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_rom_select    = r_sel;
  assign sccb.sccb_valid = r_valid;
  assign sccb.sccb_addr  = r_addr;
  assign sccb.sccb_data  = r_data;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_error         = r_err;

endmodule

// File: tb/tb_camera_config_ctrl.sv
// Self-checking bench for camera_config_ctrl.
// Timeout cases need CAM_CFG_TIMEOUT_EN.
module tb_camera_config_ctrl;

  localparam int DLY  = 5;
  localparam int MAXE = 4;
  localparam int TO   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_sel;
  logic [15:0] rom_out = 16'h0;
  logic        busy;
  logic        done;
  logic        err;
  logic        s_done = 1'b0;
  logic        m_done = 1'b0;

  logic [15:0] rom [0:255];

  camera_config_ctrl_if bus();

  assign bus.sccb_done = s_done | m_done;

  camera_config_ctrl #(
    .DELAY_CYCLES   (DLY),
    .MAX_ENTRIES    (MAXE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .o_rom_select (rom_sel),
    .i_rom_out    (rom_out),
    .sccb         (bus.master),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_out <= rom[rom_sel];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // SCCB slave model
  int rdy_mode = 0;
  int lat_min  = 1;
  int lat_max  = 1;
  bit done_en  = 1'b1;
  int pend     = 0;
  logic [15:0] acc_q [$];
  int          acc_cyc [$];

  initial bus.sccb_ready = 1'b0;

  always @(negedge clk) begin
    s_done = 1'b0;
    if (rst) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0 && done_en) s_done = 1'b1;
    end
    case (rdy_mode)
      0:       bus.sccb_ready = 1'b1;
      1:       bus.sccb_ready = ($urandom_range(0, 3) != 0);
      default: bus.sccb_ready = 1'b0;
    endcase
    if (!rst && bus.sccb_valid && bus.sccb_ready) begin
      acc_q.push_back({bus.sccb_addr, bus.sccb_data});
      acc_cyc.push_back(cyc);
      pend = $urandom_range(lat_min, lat_max);
    end
  end

  int overlap = 0;
  always @(negedge clk) if (busy && done) overlap++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_fin(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_pass(input string name);
    acc_q.delete();
    acc_cyc.delete();
    pulse_start();
    wait_fin(name, 2000);
  endtask

  // reference: expected writes and error from table rules
  logic [15:0] exp_q [$];
  bit          exp_err;

  task automatic model();
    bit ended = 1'b0;
    exp_q.delete();
    for (int i = 0; i <= MAXE; i++) begin
      if (!ended) begin
        if (rom[i] == 16'hFFFF) ended = 1'b1;
        else if (rom[i] != 16'hFFF0) exp_q.push_back(rom[i]);
      end
    end
    exp_err = !ended;
  endtask

  typedef struct {
    logic [15:0] e [5];
    int          nw;
    bit          er;
    logic [15:0] last;
  } vec_t;

  vec_t vt [6];

  initial begin
    int bad;
    logic [7:0] a0;
    logic [7:0] d0;
    int k;

    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;

    vt[0] = '{'{16'h1280, 16'hFFF0, 16'h1214, 16'hFFFF,
               16'hAAAA}, 2, 1'b0, 16'h1214};
    vt[1] = '{'{16'hFF12, 16'hFFFE, 16'hFFFF, 16'hAAAA,
               16'hAAAA}, 2, 1'b0, 16'hFFFE};
    vt[2] = '{'{16'h0102, 16'h0304, 16'h0506, 16'h0708,
               16'hFFFF}, 4, 1'b0, 16'h0708};
    vt[3] = '{'{16'h0102, 16'h0304, 16'h0506, 16'h0708,
               16'h090A}, 5, 1'b1, 16'h090A};
    vt[4] = '{'{16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0,
               16'hFFF0}, 0, 1'b1, 16'h0000};
    vt[5] = '{'{16'hFFFF, 16'h1111, 16'h2222, 16'h3333,
               16'h4444}, 0, 1'b0, 16'h0000};

    // reset and idle
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rom_sel !== 0 || bus.sccb_valid !== 0 ||
          bus.sccb_addr !== 0 || bus.sccb_data !== 0 ||
          busy !== 0 || done !== 0 || err !== 0) bad++;
    end
    chk("idle_outputs", bad, 0);
    chk("idle_no_accept", acc_q.size(), 0);

    // normal table, done 3 cycles after accept
    rom[0] = 16'h1280; rom[1] = 16'hFFF0;
    rom[2] = 16'h1214; rom[3] = 16'hFFFF;
    rdy_mode = 0; lat_min = 3; lat_max = 3;
    run_pass("normal");
    chk("normal_nw", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("normal_w0", acc_q[0], 16'h1280);
      chk("normal_w1", acc_q[1], 16'h1214);
      chk("normal_gap_ge7",
          (acc_cyc[1] - acc_cyc[0]) >= 7, 1);
    end
    chk("normal_done", done, 1);
    chk("normal_busy", busy, 0);
    chk("normal_err", err, 0);

    // table-driven vectors
    lat_min = 1; lat_max = 4;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 5; i++) rom[i] = vt[v].e[i];
      rom[5] = 16'h7777;
      run_pass("vec");
      chk($sformatf("vec%0d_nw", v), acc_q.size(), vt[v].nw);
      if (vt[v].nw > 0 && acc_q.size() > 0)
        chk($sformatf("vec%0d_last", v),
            acc_q[acc_q.size()-1], vt[v].last);
      chk($sformatf("vec%0d_err", v), err, vt[v].er);
      chk($sformatf("vec%0d_done", v), done, 1);
    end

    // backpressure: 20 cycles not ready, start ignored
    rom[0] = 16'h5A3C; rom[1] = 16'hFFFF;
    rdy_mode = 2;
    acc_q.delete();
    pulse_start();
    k = 0;
    while (!bus.sccb_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", bus.sccb_valid, 1);
    a0 = bus.sccb_addr;
    d0 = bus.sccb_data;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sccb_valid !== 1 || bus.sccb_addr !== a0 ||
          bus.sccb_data !== d0) bad++;
    end
    chk("bp_stable", bad, 0);
    pulse_start();
    chk("bp_start_ignored_busy", busy, 1);
    rdy_mode = 0;
    wait_fin("bp", 200);
    chk("bp_one_accept", acc_q.size(), 1);
    if (acc_q.size() == 1) chk("bp_w0", acc_q[0], 16'h5A3C);
    chk("bp_err", err, 0);

    // randomized tables against reference model
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 9))
          0:       rom[i] = 16'hFFFF;
          1:       rom[i] = 16'hFFF0;
          2:       rom[i] = {8'hFF, 8'($urandom)};
          default: rom[i] = 16'($urandom);
        endcase
      end
      model();
      run_pass("rand");
      chk($sformatf("rand%0d_nw", t),
          acc_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        if (i < acc_q.size())
          chk($sformatf("rand%0d_w%0d", t, i),
              acc_q[i], exp_q[i]);
      chk($sformatf("rand%0d_err", t), err, exp_err);
      chk($sformatf("rand%0d_done", t), done, 1);
    end

    // reset while waiting for completion
    rom[0] = 16'h1111; rom[1] = 16'h2222;
    rom[2] = 16'h3333; rom[3] = 16'hFFFF;
    rdy_mode = 0; done_en = 1'b0;
    acc_q.delete();
    pulse_start();
    k = 0;
    while (acc_q.size() == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_accept", acc_q.size(), 1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_done = 1'b1;
    tick(1);
    m_done = 1'b0;
    tick(20);
    chk("rst_mid_no_writes", acc_q.size(), 1);
    chk("rst_mid_valid", bus.sccb_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_sel", rom_sel, 0);
    chk("rst_mid_addr", bus.sccb_addr, 0);
    chk("rst_mid_data", bus.sccb_data, 0);
    done_en = 1'b1;

`ifdef CAM_CFG_TIMEOUT_EN
    // watchdog: ready never rises
    rom[0] = 16'h4321; rom[1] = 16'hFFFF;
    rdy_mode = 2;
    acc_q.delete();
    pulse_start();
    bad = 0;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.sccb_valid) bad++;
    end
    chk("to_valid_cycles", bad, TO);
    chk("to_valid_low", bus.sccb_valid, 0);
    chk("to_err", err, 1);
    chk("to_done", done, 1);
    chk("to_no_accept", acc_q.size(), 0);
    rdy_mode = 0; lat_min = 2; lat_max = 2;
    pulse_start();
    chk("to_restart_err_clr", err, 0);
    wait_fin("to_restart", 200);
    chk("to_restart_nw", acc_q.size(), 1);
    if (acc_q.size() == 1)
      chk("to_restart_w0", acc_q[0], 16'h4321);
    chk("to_restart_err", err, 0);
`endif

    chk("busy_done_exclusive", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
